// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction controller:
// state encoding, default widths and the saturating credit adder.
package vend_pkg;

    localparam int CW_DEFAULT      = 7;
    localparam int IAW_DEFAULT     = 10;
    localparam int TIMEOUT_DEFAULT = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_LOOKUP,
        ST_DISPENSE,
        ST_WAIT_RESULT,
        ST_UPDATE,
        ST_REFUND,
        ST_DONE
    } vend_state_e;

    function automatic int unsigned sat_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned lim
    );
        int unsigned s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/vend_credit_timer.sv
// Saturating coin credit accumulator with an idle timer that
// flags expiry after TIMEOUT coin-free cycles in collection.
module vend_credit_timer
    import vend_pkg::*;
#(
    parameter int CW      = CW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_load,
    input  logic          i_add,
    input  logic          i_run,
    input  logic          i_clear,
    input  logic [CW-1:0] i_coin,
    output logic [CW-1:0] o_credit,
    output logic [CW-1:0] o_credit_nxt,
    output logic          o_expire
);

    localparam int          TW   = $clog2(TIMEOUT);
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic [CW-1:0] r_credit;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] w_sum;

    assign w_sum = CW'(sat_add(32'(r_credit), 32'(i_coin), CMAX));

    always_comb begin
        o_credit_nxt = r_credit;
        if (i_load)
            o_credit_nxt = i_coin;
        else if (i_add)
            o_credit_nxt = w_sum;
    end

    assign o_credit = r_credit;

    // A coin in the last idle cycle wins over expiry and restarts the count.
    assign o_expire = i_run && !i_add &&
                      (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit <= '0;
            r_timer  <= '0;
        end else if (i_clear) begin
            r_credit <= '0;
            r_timer  <= '0;
        end else begin
            r_credit <= o_credit_nxt;
            if (i_load || i_add)
                r_timer <= '0;
            else if (i_run && !o_expire)
                r_timer <= r_timer + 1'b1;
        end
    end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit collection, item lookup,
// dispense trigger, stock write-back and cancel/timeout refunds.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int CURRENCY_WIDTH  = CW_DEFAULT,
    parameter int ITEM_ADDR_WIDTH = IAW_DEFAULT,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       coin_valid,
    input  logic [CURRENCY_WIDTH-1:0]  coin_value,
    input  logic                       sel_valid,
    input  logic [ITEM_ADDR_WIDTH-1:0] sel_item,
    input  logic                       cancel,
    output logic                       mem_rd_req,
    output logic [ITEM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                       mem_rd_ack,
    input  logic [15:0]                mem_item_price,
    input  logic [7:0]                 mem_avail_count,
    output logic                       mem_wr_en,
    output logic [ITEM_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [7:0]                 mem_wr_count,
    output logic                       dispense_enable,
    output logic [ITEM_ADDR_WIDTH-1:0] item_selected,
    output logic [CURRENCY_WIDTH-1:0]  total_currency,
    output logic [15:0]                item_price_q,
    output logic [7:0]                 avail_count_q,
    input  logic                       dispense_valid,
    output logic                       refund_valid,
    output logic [CURRENCY_WIDTH-1:0]  refund_amount,
    output logic                       txn_done,
    output logic                       busy
);

    localparam int CW  = CURRENCY_WIDTH;
    localparam int IAW = ITEM_ADDR_WIDTH;

    vend_state_e    r_state;
    logic [IAW-1:0] r_item;
    logic [15:0]    r_price;
    logic [7:0]     r_count;
    logic [7:0]     r_wr_count;
    logic           r_rd_req;
    logic           r_wr_en;
    logic           r_de;
    logic           r_refund;
    logic [CW-1:0]  r_refund_amt;
    logic           r_done;
    logic           r_busy;

    logic           w_load;
    logic           w_add;
    logic           w_run;
    logic           w_clear;
    logic           w_expire;
    logic [CW-1:0]  w_credit;
    logic [CW-1:0]  w_credit_nxt;

    assign w_load  = (r_state == ST_IDLE) && coin_valid;
    assign w_add   = (r_state == ST_COLLECT) && coin_valid;
    assign w_run   = (r_state == ST_COLLECT);
    assign w_clear = (r_state == ST_DONE);

    vend_credit_timer #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT_CYCLES)
    ) u_credit (
        .clk          (clk),
        .rstn         (rstn),
        .i_load       (w_load),
        .i_add        (w_add),
        .i_run        (w_run),
        .i_clear      (w_clear),
        .i_coin       (coin_value),
        .o_credit     (w_credit),
        .o_credit_nxt (w_credit_nxt),
        .o_expire     (w_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_item       <= '0;
            r_price      <= '0;
            r_count      <= '0;
            r_wr_count   <= '0;
            r_rd_req     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_de         <= 1'b0;
            r_refund     <= 1'b0;
            r_refund_amt <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_de     <= 1'b0;
            r_wr_en  <= 1'b0;
            r_refund <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (coin_valid) begin
                        r_state <= ST_COLLECT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    // Same-cycle coin is already folded into w_credit_nxt.
                    if (cancel || w_expire) begin
                        r_state      <= ST_REFUND;
                        r_refund     <= 1'b1;
                        r_refund_amt <= w_credit_nxt;
                    end else if (sel_valid) begin
                        r_state  <= ST_LOOKUP;
                        r_item   <= sel_item;
                        r_rd_req <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (mem_rd_ack) begin
                        r_state  <= ST_DISPENSE;
                        r_price  <= mem_item_price;
                        r_count  <= mem_avail_count;
                        r_rd_req <= 1'b0;
                        r_de     <= 1'b1;
                    end else if (cancel) begin
                        r_state      <= ST_REFUND;
                        r_rd_req     <= 1'b0;
                        r_refund     <= 1'b1;
                        r_refund_amt <= w_credit;
                    end
                end
                ST_DISPENSE: begin
                    r_state <= ST_WAIT_RESULT;
                end
                ST_WAIT_RESULT: begin
                    if (dispense_valid) begin
                        r_state    <= ST_UPDATE;
                        r_wr_en    <= 1'b1;
                        r_wr_count <= r_count - 8'd1;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_REFUND: begin
                    r_state      <= ST_DONE;
                    r_done       <= 1'b1;
                    r_refund_amt <= '0;
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_item     <= '0;
                    r_price    <= '0;
                    r_count    <= '0;
                    r_wr_count <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_req      = r_rd_req;
    assign mem_rd_addr     = r_item;
    assign mem_wr_en       = r_wr_en;
    assign mem_wr_addr     = r_item;
    assign mem_wr_count    = r_wr_count;
    assign dispense_enable = r_de;
    assign item_selected   = r_item;
    assign total_currency  = w_credit;
    assign item_price_q    = r_price;
    assign avail_count_q   = r_count;
    assign refund_valid    = r_refund;
    assign refund_amount   = r_refund_amt;
    assign txn_done        = r_done;
    assign busy            = r_busy;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Randomized bench for vend_txn_controller; the bench plays item
// memory and output_logic and predicts each transaction's outcome.
module tb_vend_txn_controller;

    localparam int CW   = 7;
    localparam int IAW  = 10;
    localparam int TO   = 1000;
    localparam int CMAX = 127;

    localparam int K_SEL    = 0;
    localparam int K_CANCEL = 1;
    localparam int K_CLOOK  = 2;
    localparam int K_TMO    = 3;

    logic           clk = 1'b0;
    logic           rstn;
    logic           coin_valid;
    logic [CW-1:0]  coin_value;
    logic           sel_valid;
    logic [IAW-1:0] sel_item;
    logic           cancel;
    logic           mem_rd_req;
    logic [IAW-1:0] mem_rd_addr;
    logic           mem_rd_ack;
    logic [15:0]    mem_item_price;
    logic [7:0]     mem_avail_count;
    logic           mem_wr_en;
    logic [IAW-1:0] mem_wr_addr;
    logic [7:0]     mem_wr_count;
    logic           dispense_enable;
    logic [IAW-1:0] item_selected;
    logic [CW-1:0]  total_currency;
    logic [15:0]    item_price_q;
    logic [7:0]     avail_count_q;
    logic           dispense_valid;
    logic           refund_valid;
    logic [CW-1:0]  refund_amount;
    logic           txn_done;
    logic           busy;

    always #5 clk = ~clk;

    vend_txn_controller #(
        .CURRENCY_WIDTH  (CW),
        .ITEM_ADDR_WIDTH (IAW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .coin_valid      (coin_valid),
        .coin_value      (coin_value),
        .sel_valid       (sel_valid),
        .sel_item        (sel_item),
        .cancel          (cancel),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_ack      (mem_rd_ack),
        .mem_item_price  (mem_item_price),
        .mem_avail_count (mem_avail_count),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_count    (mem_wr_count),
        .dispense_enable (dispense_enable),
        .item_selected   (item_selected),
        .total_currency  (total_currency),
        .item_price_q    (item_price_q),
        .avail_count_q   (avail_count_q),
        .dispense_valid  (dispense_valid),
        .refund_valid    (refund_valid),
        .refund_amount   (refund_amount),
        .txn_done        (txn_done),
        .busy            (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Pulse monitor: counts and captures every output event.
    int             n_de = 0, n_wr = 0, n_ref = 0, n_done = 0, n_glitch = 0;
    int             cap_tot, cap_item, cap_price, cap_cnt;
    int             cap_wa, cap_wc, cap_ra;
    logic           prev_req = 1'b0;
    logic [IAW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (dispense_enable) begin
            n_de++;
            cap_tot   = int'(total_currency);
            cap_item  = int'(item_selected);
            cap_price = int'(item_price_q);
            cap_cnt   = int'(avail_count_q);
        end
        if (mem_wr_en) begin
            n_wr++;
            cap_wa = int'(mem_wr_addr);
            cap_wc = int'(mem_wr_count);
        end
        if (refund_valid) begin
            n_ref++;
            cap_ra = int'(refund_amount);
        end
        if (txn_done)
            n_done++;
        if (mem_rd_req && prev_req && (mem_rd_addr != prev_addr))
            n_glitch++;
        prev_req  = mem_rd_req;
        prev_addr = mem_rd_addr;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int sat(input int s);
        return (s > CMAX) ? CMAX : s;
    endfunction

    task automatic wait_done(input int b_done);
        int w;
        w = 0;
        while (n_done == b_done && w < 20) begin
            tick();
            w++;
        end
        check("txn_done_pulse", n_done - b_done, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_credit", total_currency, 0);
        check("idle_rd_req", mem_rd_req, 0);
        check("done_single", n_done - b_done, 1);
    endtask

    task automatic wait_req();
        int w;
        w = 0;
        while (!mem_rd_req && w < 8) begin
            tick();
            w++;
        end
        check("rd_req_seen", mem_rd_req, 1);
    endtask

    task automatic run_txn(input int kind, input bit big, input bit restart);
        int nc, sum, c, credit, item, price, cnt, dly, dv, held, w;
        int b_de, b_wr, b_ref, b_done, b_gl;
        bit tail;
        b_de = n_de; b_wr = n_wr; b_ref = n_ref;
        b_done = n_done; b_gl = n_glitch;
        nc  = $urandom_range(1, 4);
        sum = 0;
        for (int i = 0; i < nc; i++) begin
            c = big ? $urandom_range(40, 127) : $urandom_range(1, 30);
            coin_valid = 1'b1;
            coin_value = CW'(c);
            sum += c;
            tick();
            coin_valid = 1'b0;
            if (i < nc - 1 || kind != K_TMO)
                repeat ($urandom_range(0, 3)) tick();
        end
        tail = (kind == K_SEL || kind == K_CANCEL) && ($urandom_range(0, 1) == 1);
        c = $urandom_range(1, 30);
        item  = $urandom_range(0, 1023);
        price = $urandom_range(0, 65535);
        cnt   = $urandom_range(1, 255);
        dly   = $urandom_range(0, 25);
        dv    = $urandom_range(0, 1);

        if (kind == K_SEL || kind == K_CLOOK) begin
            sel_valid = 1'b1;
            sel_item  = IAW'(item);
            if (tail) begin
                coin_valid = 1'b1;
                coin_value = CW'(c);
                sum += c;
            end
            tick();
            sel_valid  = 1'b0;
            coin_valid = 1'b0;
            sel_item   = IAW'($urandom);
            credit = sat(sum);
            wait_req();
            check("rd_addr", mem_rd_addr, item);
            if (kind == K_CLOOK) begin
                repeat ($urandom_range(0, 5)) tick();
                cancel = 1'b1;
                tick();
                cancel = 1'b0;
                check("clook_req_drop", mem_rd_req, 0);
                check("clook_refund", refund_valid, 1);
                check("clook_amount", refund_amount, credit);
                wait_done(b_done);
                check("clook_no_de", n_de - b_de, 0);
                check("clook_ref_cnt", n_ref - b_ref, 1);
            end else begin
                held = 0;
                for (int d = 0; d < dly; d++) begin
                    coin_valid = 1'($urandom_range(0, 1));
                    coin_value = CW'($urandom_range(1, 127));
                    tick();
                    if (mem_rd_req) held++;
                end
                check("rd_req_held", held, dly);
                coin_valid      = 1'b0;
                mem_rd_ack      = 1'b1;
                mem_item_price  = 16'(price);
                mem_avail_count = 8'(cnt);
                tick();
                mem_rd_ack      = 1'b0;
                mem_item_price  = 16'($urandom);
                mem_avail_count = 8'($urandom);
                check("rd_req_drop", mem_rd_req, 0);
                check("de_now", dispense_enable, 1);
                cancel     = 1'b1;
                coin_valid = 1'b1;
                coin_value = 7'd5;
                tick();
                cancel         = 1'b0;
                coin_valid     = 1'b0;
                dispense_valid = 1'(dv);
                tick();
                dispense_valid = 1'b0;
                wait_done(b_done);
                check("de_count", n_de - b_de, 1);
                check("de_total", cap_tot, credit);
                check("de_item", cap_item, item);
                check("de_price", cap_price, price);
                check("de_stock", cap_cnt, cnt);
                check("wr_count_pulses", n_wr - b_wr, dv);
                check("sel_no_refund", n_ref - b_ref, 0);
                check("rd_addr_stable", n_glitch - b_gl, 0);
                if (dv == 1) begin
                    check("wr_addr", cap_wa, item);
                    check("wr_stock", cap_wc, cnt - 1);
                end
            end
        end else if (kind == K_CANCEL) begin
            cancel = 1'b1;
            if (tail) begin
                coin_valid = 1'b1;
                coin_value = CW'(c);
                sum += c;
            end
            tick();
            cancel     = 1'b0;
            coin_valid = 1'b0;
            credit = sat(sum);
            wait_done(b_done);
            check("cancel_ref_cnt", n_ref - b_ref, 1);
            check("cancel_amount", cap_ra, credit);
            check("cancel_no_de", n_de - b_de, 0);
            check("cancel_no_wr", n_wr - b_wr, 0);
        end else begin
            if (restart) begin
                repeat (TO - 1) tick();
                coin_valid = 1'b1;
                coin_value = CW'(c);
                sum += c;
                tick();
                coin_valid = 1'b0;
            end
            credit = sat(sum);
            w = 1;
            while (!refund_valid && w < TO + 100) begin
                tick();
                w++;
            end
            check("timeout_cycles", w, TO + 1);
            check("timeout_amount", refund_amount, credit);
            wait_done(b_done);
            check("timeout_ref_cnt", n_ref - b_ref, 1);
            check("timeout_no_de", n_de - b_de, 0);
        end
    endtask

    task automatic reset_mid_update();
        int b_wr;
        coin_valid = 1'b1;
        coin_value = 7'd30;
        tick();
        coin_valid = 1'b0;
        sel_valid  = 1'b1;
        sel_item   = 10'd9;
        tick();
        sel_valid = 1'b0;
        wait_req();
        mem_rd_ack      = 1'b1;
        mem_item_price  = 16'd10;
        mem_avail_count = 8'd3;
        tick();
        mem_rd_ack = 1'b0;
        tick();
        dispense_valid = 1'b1;
        b_wr = n_wr;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        dispense_valid = 1'b0;
        tick();
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_wr_pulses", n_wr - b_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_credit", total_currency, 0);
        check("rst_item", item_selected, 0);
        check("rst_price", item_price_q, 0);
        check("rst_stock", avail_count_q, 0);
        check("rst_wr_count", mem_wr_count, 0);
        rstn = 1'b1;
        tick();
        sel_valid = 1'b1;
        sel_item  = 10'd5;
        cancel    = 1'b1;
        tick();
        sel_valid = 1'b0;
        cancel    = 1'b0;
        tick();
        check("idle_sel_busy", busy, 0);
        check("idle_sel_req", mem_rd_req, 0);
        check("idle_cancel_ref", refund_valid, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        rstn            = 1'b0;
        coin_valid      = 1'b0;
        coin_value      = '0;
        sel_valid       = 1'b0;
        sel_item        = '0;
        cancel          = 1'b0;
        mem_rd_ack      = 1'b0;
        mem_item_price  = '0;
        mem_avail_count = '0;
        dispense_valid  = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_credit", total_currency, 0);
        check("reset_rd_req", mem_rd_req, 0);
        check("reset_de", dispense_enable, 0);
        check("reset_refund", refund_valid, 0);
        check("reset_done", txn_done, 0);
        check("reset_wr_en", mem_wr_en, 0);
        rstn = 1'b1;
        tick();
        check("post_reset_busy", busy, 0);

        run_txn(K_SEL, 1'b1, 1'b0);
        run_txn(K_CANCEL, 1'b0, 1'b0);
        run_txn(K_TMO, 1'b0, 1'b0);
        run_txn(K_TMO, 1'b0, 1'b1);
        reset_mid_update();
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            run_txn((r < 5) ? K_SEL : (r < 8) ? K_CANCEL : K_CLOOK,
                    $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
